// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_ctrl
// Purpose  : N-stage in-order pipeline sequencer. Holds per-stage valid and
//            payload registers and handles stalls, flushes and drain. Also
//            keeps saturating perf counters.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_ctrl #(
    parameter int NUM_STAGES = 5,
    parameter int DATA_W     = 32,
    parameter int CNT_W      = 32,
    parameter int SW         = $clog2(NUM_STAGES)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic [DATA_W-1:0]            in_data,
    output logic                         in_ready,
    output logic [NUM_STAGES-1:0]        stage_valid,
    output logic [NUM_STAGES*DATA_W-1:0] stage_data,
    input  logic [NUM_STAGES*DATA_W-1:0] stage_result,
    input  logic [NUM_STAGES-1:0]        stall_req,
    input  logic                         flush_req,
    input  logic [SW-1:0]                flush_stage,
    input  logic                         drain_req,
    output logic                         drain_done,
    output logic                         retire_valid,
    output logic [DATA_W-1:0]            retire_data,
    input  logic                         clr_cnt,
    output logic [CNT_W-1:0]             cnt_retired,
    output logic [CNT_W-1:0]             cnt_stall,
    output logic [CNT_W-1:0]             cnt_flush
);

    localparam logic [1:0]  ST_RUN      = 2'd0;
    localparam logic [1:0]  ST_DRAIN    = 2'd1;
    localparam logic [1:0]  ST_IDLE     = 2'd2;
    localparam logic [SW:0] STAGE_LIMIT = (SW+1)'(NUM_STAGES);

    logic [1:0]                        state_q, state_d;
    logic [NUM_STAGES-1:0]             valid_q, valid_d;
    logic [NUM_STAGES-1:0][DATA_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]                  ret_q, ret_d;
    logic [CNT_W-1:0]                  stl_q, stl_d;
    logic [CNT_W-1:0]                  fls_q, fls_d;

    logic [NUM_STAGES-1:0][DATA_W-1:0] w_result;
    logic [NUM_STAGES-1:0]             w_hold;
    logic [NUM_STAGES-1:0]             w_clear;
    logic                              w_flush_ok;

    assign w_result   = stage_result;
    assign w_flush_ok = flush_req & ({1'b0, flush_stage} < STAGE_LIMIT);

    // A stall anywhere downstream freezes this stage too; a flush kills
    // everything younger than the flusher, and the flusher itself unless held.
    generate
        for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
            assign w_hold[k]  = |stall_req[NUM_STAGES-1:k];
            assign w_clear[k] = w_flush_ok &
                                (((SW+1)'(k) <  {1'b0, flush_stage}) |
                                 (((SW+1)'(k) == {1'b0, flush_stage}) & ~w_hold[k]));
        end
    endgenerate

    assign in_ready     = ~w_hold[0] & ~flush_req & (state_q == ST_RUN) & ~drain_req;
    assign retire_valid = valid_q[NUM_STAGES-1] & ~w_hold[NUM_STAGES-1];
    assign retire_data  = w_result[NUM_STAGES-1];
    assign stage_valid  = valid_q;
    assign stage_data   = data_q;
    assign cnt_retired  = ret_q;
    assign cnt_stall    = stl_q;
    assign cnt_flush    = fls_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (!w_hold[0]) begin
            valid_d[0] = in_valid & in_ready;
            data_d[0]  = in_data;
        end
        for (int k = 1; k < NUM_STAGES; k++) begin
            if (!w_hold[k]) begin
                valid_d[k] = valid_q[k-1] & ~w_hold[k-1];
                data_d[k]  = w_result[k-1];
            end
        end
        valid_d = valid_d & ~w_clear;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    // Drain FSM: state register / next state / outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_RUN;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (drain_req) state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (!drain_req)        state_d = ST_RUN;
                else if (~|valid_q)    state_d = ST_IDLE;
            end
            ST_IDLE:  if (!drain_req) state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    always_comb begin
        drain_done = (state_q == ST_IDLE);
    end

    function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cur,
                                                   input logic inc,
                                                   input logic clr);
        if (clr)                   return '0;
        if (inc && (cur != '1))    return cur + CNT_W'(1);
        return cur;
    endfunction

    always_comb begin
        ret_d = cnt_next(ret_q, retire_valid, clr_cnt);
        stl_d = cnt_next(stl_q, w_hold[0],    clr_cnt);
        fls_d = cnt_next(fls_q, w_flush_ok,   clr_cnt);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ret_q <= '0;
            stl_q <= '0;
            fls_q <= '0;
        end else begin
            ret_q <= ret_d;
            stl_q <= stl_d;
            fls_q <= fls_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_ctrl
// Purpose  : Directed plus randomized bench for pipeline_ctrl, with a
//            behavioural pipeline model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_ctrl;

    localparam int N    = 5;
    localparam int DW   = 8;
    localparam int CW   = 6;
    localparam int SWB  = 3;
    localparam int CMAX = (1 << CW) - 1;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic [DW-1:0]   in_data;
    logic            in_ready;
    logic [N-1:0]    stage_valid;
    logic [N*DW-1:0] stage_data;
    logic [N*DW-1:0] stage_result;
    logic [N-1:0]    stall_req;
    logic            flush_req;
    logic [SWB-1:0]  flush_stage;
    logic            drain_req;
    logic            drain_done;
    logic            retire_valid;
    logic [DW-1:0]   retire_data;
    logic            clr_cnt;
    logic [CW-1:0]   cnt_retired, cnt_stall, cnt_flush;

    pipeline_ctrl #(.NUM_STAGES(N), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .stage_valid(stage_valid), .stage_data(stage_data),
        .stage_result(stage_result), .stall_req(stall_req),
        .flush_req(flush_req), .flush_stage(flush_stage),
        .drain_req(drain_req), .drain_done(drain_done),
        .retire_valid(retire_valid), .retire_data(retire_data),
        .clr_cnt(clr_cnt), .cnt_retired(cnt_retired),
        .cnt_stall(cnt_stall), .cnt_flush(cnt_flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stage logic stand-in: each stage adds one to its payload.
    always_comb begin
        stage_result = '0;
        for (int k = 0; k < N; k++)
            stage_result[k*DW +: DW] = stage_data[k*DW +: DW] + 8'd1;
    end

    typedef enum int {M_RUN, M_DRAIN, M_IDLE} mstate_t;
    bit            m_valid [N];
    logic [DW-1:0] m_data  [N];
    mstate_t       m_state;
    int            m_ret, m_stall, m_flush;
    int            checks, errors;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_valid[k] = 1'b0;
            m_data[k]  = '0;
        end
        m_state = M_RUN;
        m_ret   = 0;
        m_stall = 0;
        m_flush = 0;
    endtask

    function automatic int sat_inc(input int v);
        return (v < CMAX) ? v + 1 : v;
    endfunction

    // One clock: called just after a falling edge with inputs already driven.
    task automatic step();
        int            hs;
        int            f;
        bit            rdy, rv, empty;
        bit            nv [N];
        logic [DW-1:0] nd [N];
        logic [DW-1:0] exp8;
        logic [N-1:0]  ev;
        #1;
        hs = -1;
        for (int j = 0; j < N; j++) if (stall_req[j]) hs = j;
        f     = int'(flush_stage);
        rdy   = (hs < 0) && !flush_req && (m_state == M_RUN) && !drain_req;
        rv    = m_valid[N-1] && (hs != N-1);
        exp8  = m_data[N-1] + 8'd1;
        empty = 1'b1;
        for (int k = 0; k < N; k++) if (m_valid[k]) empty = 1'b0;
        chk("in_ready", in_ready, rdy);
        chk("retire_valid", retire_valid, rv);
        if (rv) chk("retire_data", retire_data, exp8);

        for (int k = 0; k < N; k++) begin
            nv[k] = m_valid[k];
            nd[k] = m_data[k];
        end
        for (int k = N-1; k >= 1; k--) begin
            if (k > hs) begin
                nv[k] = m_valid[k-1] && (k-1 > hs);
                nd[k] = m_data[k-1] + 8'd1;
            end
        end
        if (hs < 0) begin
            nv[0] = in_valid && rdy;
            nd[0] = in_data;
        end
        if (flush_req && f < N) begin
            for (int k = 0; k < f; k++) nv[k] = 1'b0;
            if (f > hs) nv[f] = 1'b0;
        end

        if (clr_cnt) begin
            m_ret = 0; m_stall = 0; m_flush = 0;
        end else begin
            if (rv)                   m_ret   = sat_inc(m_ret);
            if (hs >= 0)              m_stall = sat_inc(m_stall);
            if (flush_req && f < N)   m_flush = sat_inc(m_flush);
        end

        case (m_state)
            M_RUN:   if (drain_req) m_state = M_DRAIN;
            M_DRAIN: if (!drain_req) m_state = M_RUN;
                     else if (empty) m_state = M_IDLE;
            M_IDLE:  if (!drain_req) m_state = M_RUN;
            default: m_state = M_RUN;
        endcase

        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            m_valid[k] = nv[k];
            m_data[k]  = nd[k];
            ev[k]      = nv[k];
        end
        chk("stage_valid", stage_valid, ev);
        for (int k = 0; k < N; k++)
            if (m_valid[k]) chk($sformatf("stage_data%0d", k), stage_data[k*DW +: DW], m_data[k]);
        chk("cnt_retired", cnt_retired, m_ret);
        chk("cnt_stall", cnt_stall, m_stall);
        chk("cnt_flush", cnt_flush, m_flush);
        chk("drain_done", drain_done, m_state == M_IDLE);
        @(negedge clk);
    endtask

    task automatic inject(input int cnt, input logic [DW-1:0] base);
        in_valid = 1'b1;
        for (int i = 0; i < cnt; i++) begin
            in_data = base + DW'(i);
            step();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0; errors = 0;
        rst = 1'b0; in_valid = 1'b0; in_data = '0; stall_req = '0;
        flush_req = 1'b0; flush_stage = '0; drain_req = 1'b0; clr_cnt = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_stage_valid", stage_valid, '0);
        chk("rst_stage_data", stage_data, '0);
        chk("rst_cnt_retired", cnt_retired, '0);
        chk("rst_drain_done", drain_done, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        rst = 1'b1;

        // Back-to-back stream of three
        inject(3, 8'h10);
        repeat (6) step();
        chk("stream_cnt_retired", cnt_retired, 3);

        // Stall at stage 3 for two cycles with stages 0..3 occupied
        inject(4, 8'h20);
        stall_req = 5'b01000;
        in_valid = 1'b1; in_data = 8'h24;
        repeat (2) step();
        stall_req = '0; in_valid = 1'b0;
        chk("stall_cnt", cnt_stall, 2);
        repeat (8) step();

        // Flush at stage 2 with all stages valid
        inject(6, 8'h30);
        flush_req = 1'b1; flush_stage = 3'd2; in_valid = 1'b1; in_data = 8'h40;
        step();
        flush_req = 1'b0; in_valid = 1'b0;
        chk("flush_cnt", cnt_flush, 1);
        repeat (6) step();

        // Flush at stage 2 while the last stage stalls
        inject(5, 8'h50);
        flush_req = 1'b1; flush_stage = 3'd2; stall_req = 5'b10000;
        step();
        flush_req = 1'b0; stall_req = '0;
        repeat (7) step();

        // Out-of-range flush index is ignored
        inject(5, 8'h60);
        flush_req = 1'b1; flush_stage = 3'd6;
        step();
        flush_req = 1'b0;
        chk("flush_oor_cnt", cnt_flush, 2);
        repeat (6) step();

        // Drain with three in flight while fetch keeps offering
        inject(3, 8'h70);
        in_valid = 1'b1; in_data = 8'h7F; drain_req = 1'b1;
        for (int i = 0; i < 20 && !drain_done; i++) step();
        chk("drain_reached_idle", drain_done, 1'b1);
        in_valid = 1'b0; drain_req = 1'b0;
        step();
        step();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = DW'($urandom);
            for (int j = 0; j < N; j++) stall_req[j] = ($urandom_range(0, 7) == 0);
            flush_req   = ($urandom_range(0, 15) == 0);
            flush_stage = SWB'($urandom_range(0, N-1));
            if ($urandom_range(0, 39) == 0) drain_req = ~drain_req;
            clr_cnt = ($urandom_range(0, 63) == 0);
            step();
        end
        in_valid = 1'b0; stall_req = '0; flush_req = 1'b0; drain_req = 1'b0; clr_cnt = 1'b0;
        repeat (8) step();

        // Retired counter saturation
        clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 75; i++) begin
            in_data = DW'($urandom);
            step();
        end
        in_valid = 1'b0;
        repeat (6) step();
        chk("sat_cnt_retired", cnt_retired, CMAX);

        // Asynchronous reset in the middle of a stall
        inject(3, 8'h90);
        stall_req = 5'b00010; in_valid = 1'b1;
        repeat (3) step();
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        chk("arst_stage_valid", stage_valid, '0);
        chk("arst_stage_data", stage_data, '0);
        chk("arst_cnt_retired", cnt_retired, '0);
        chk("arst_cnt_stall", cnt_stall, '0);
        chk("arst_cnt_flush", cnt_flush, '0);
        chk("arst_drain_done", drain_done, 1'b0);
        chk("arst_in_ready", in_ready, 1'b0);
        stall_req = '0;
        @(posedge clk);
        #1;
        chk("arst_hold_valid", stage_valid, '0);
        chk("arst_hold_cnt_stall", cnt_stall, '0);
        @(negedge clk);
        rst = 1'b1;
        inject(2, 8'hA0);
        repeat (6) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
